// File: rtl/prime_bcd_seq.sv
// Iterative shift/add-3 binary-to-BCD converter with a one-deep pending
// buffer, overflow saturation and leading-zero blanking of the display enables.
module prime_bcd_seq #(
    parameter int unsigned N_BITS   = 20,
    parameter int unsigned N_DIGITS = 6,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn_signal,
    input  logic [N_BITS-1:0]       bin_i,
    input  logic                    bin_valid_i,
    output logic                    busy_o,
    output logic [4*N_DIGITS-1:0]   bcd_o,
    output logic [N_DIGITS-1:0]     digit_en_o,
    output logic                    ovf_o,
    output logic                    done_o
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(N_BITS + 1);
    localparam int unsigned CMP_W = N_BITS + 1;
    localparam logic [CMP_W-1:0] MAX_VAL   = CMP_W'(pow10(N_DIGITS) - 64'd1);
    localparam logic [BCD_W-1:0] ALL_NINES = {N_DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t              state, state_d;
    logic [N_BITS-1:0]   bin_sr, sr_d;
    logic [BCD_W-1:0]    bcd_acc, acc_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                ovf_int, ovf_int_d;
    logic [N_BITS-1:0]   pend_val, pend_d;
    logic                pend_flag, pflag_d;
    logic [BCD_W-1:0]    bcd_d;
    logic [N_DIGITS-1:0] en_d;
    logic                ovf_d, done_d;
    logic                load_en;
    logic [N_BITS-1:0]   load_val;
    logic [BCD_W-1:0]    shift_acc, fin_bcd;
    logic [N_DIGITS-1:0] fin_en;

    // Datapath: one add-3/shift step and the result/enable seen at FINISH
    always_comb begin
        logic [3:0] nib;
        logic       carry;
        logic       seen;
        shift_acc = '0;
        nib       = '0;
        carry     = bin_sr[N_BITS-1];
        for (int k = 0; k < N_DIGITS; k++) begin
            nib = bcd_acc[4*k +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            shift_acc[4*k +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
        fin_bcd = ovf_int ? ALL_NINES : bcd_acc;
        fin_en  = '0;
        seen    = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            seen      = seen | (|fin_bcd[4*k +: 4]);
            fin_en[k] = seen || (k == 0) || !BLANK_LZ;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_d   = state;
        sr_d      = bin_sr;
        acc_d     = bcd_acc;
        cnt_d     = cnt;
        ovf_int_d = ovf_int;
        pend_d    = pend_val;
        pflag_d   = pend_flag;
        bcd_d     = bcd_o;
        en_d      = digit_en_o;
        ovf_d     = ovf_o;
        done_d    = 1'b0;
        load_en   = 1'b0;
        load_val  = bin_i;

        case (state)
            IDLE: begin
                if (bin_valid_i) load_en = 1'b1;
            end
            SHIFT: begin
                acc_d = shift_acc;
                sr_d  = {bin_sr[N_BITS-2:0], 1'b0};
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_d = FINISH;
                if (bin_valid_i) begin
                    pend_d  = bin_i;
                    pflag_d = 1'b1;
                end
            end
            FINISH: begin
                bcd_d  = fin_bcd;
                en_d   = fin_en;
                ovf_d  = ovf_int;
                done_d = 1'b1;
                if (bin_valid_i) begin
                    load_en = 1'b1;
                    pflag_d = 1'b0;
                end else if (pend_flag) begin
                    load_en  = 1'b1;
                    load_val = pend_val;
                    pflag_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            sr_d      = load_val;
            ovf_int_d = {1'b0, load_val} > MAX_VAL;
            acc_d     = '0;
            cnt_d     = CNT_W'(N_BITS);
            state_d   = SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            state      <= IDLE;
            bin_sr     <= '0;
            bcd_acc    <= '0;
            cnt        <= '0;
            ovf_int    <= 1'b0;
            pend_val   <= '0;
            pend_flag  <= 1'b0;
            bcd_o      <= '0;
            digit_en_o <= N_DIGITS'(1);
            ovf_o      <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_d;
            bin_sr     <= sr_d;
            bcd_acc    <= acc_d;
            cnt        <= cnt_d;
            ovf_int    <= ovf_int_d;
            pend_val   <= pend_d;
            pend_flag  <= pflag_d;
            bcd_o      <= bcd_d;
            digit_en_o <= en_d;
            ovf_o      <= ovf_d;
            done_o     <= done_d;
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_prime_bcd_seq.sv
// Scoreboard bench for prime_bcd_seq: a timestamped transaction model predicts
// which requests get converted, when, and the decimal result.
module tb_prime_bcd_seq;

    localparam int unsigned N_BITS  = 20;
    localparam int unsigned MAX_DEC = 999999;

    logic        clk = 1'b0;
    logic        rstn_signal = 1'b0;
    logic [19:0] bin_i = '0;
    logic        bin_valid_i = 1'b0;

    logic        busy, ovf, done, busy_nb, ovf_nb, done_nb;
    logic [23:0] bcd, bcd_nb;
    logic [5:0]  en, en_nb;

    prime_bcd_seq #(.N_BITS(20), .N_DIGITS(6), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rstn_signal(rstn_signal), .bin_i(bin_i), .bin_valid_i(bin_valid_i),
        .busy_o(busy), .bcd_o(bcd), .digit_en_o(en), .ovf_o(ovf), .done_o(done));

    prime_bcd_seq #(.N_BITS(20), .N_DIGITS(6), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rstn_signal(rstn_signal), .bin_i(bin_i), .bin_valid_i(bin_valid_i),
        .busy_o(busy_nb), .bcd_o(bcd_nb), .digit_en_o(en_nb), .ovf_o(ovf_nb), .done_o(done_nb));

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  en;
        logic        ovf;
        int          fin;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_fin = 0;
    bit          m_pend_f = 1'b0;
    int unsigned m_pend_v = 0;

    logic [23:0] last_bcd = '0;
    logic [5:0]  last_en = 6'd1;
    logic        last_ovf = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d t=%0t", name, act, exp, cyc, $time);
        end
    endfunction

    // Decimal result from plain arithmetic
    function automatic exp_t expect_of(int unsigned v, int fin);
        exp_t        e;
        int unsigned tmp;
        e.fin = fin;
        if (v > MAX_DEC) begin
            e.bcd = 24'h999999;
            e.ovf = 1'b1;
            e.en  = 6'h3f;
        end else begin
            e.ovf = 1'b0;
            e.bcd = '0;
            e.en  = '0;
            tmp   = v;
            for (int k = 0; k < 6; k++) begin
                e.bcd[4*k +: 4] = 4'(tmp % 10);
                e.en[k] = (k == 0) || (tmp != 0);
                tmp = tmp / 10;
            end
        end
        return e;
    endfunction

    function automatic void start_conv(int unsigned v);
        m_active = 1'b1;
        m_fin    = cyc + N_BITS + 1;
        q.push_back(expect_of(v, m_fin));
    endfunction

    // Reference model: who gets converted and on which edge it completes
    always @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            m_active = 1'b0;
            m_pend_f = 1'b0;
            q.delete();
            cyc = 0;
        end else begin
            cyc++;
            if (m_active && cyc == m_fin) begin
                if (bin_valid_i) begin
                    start_conv(32'(bin_i));
                    m_pend_f = 1'b0;
                end else if (m_pend_f) begin
                    start_conv(m_pend_v);
                    m_pend_f = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                if (bin_valid_i) begin
                    m_pend_v = 32'(bin_i);
                    m_pend_f = 1'b1;
                end
            end else if (bin_valid_i) begin
                start_conv(32'(bin_i));
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard each cycle
    always @(negedge clk) begin
        exp_t e;
        bit   exp_done;
        if (!rstn_signal) begin
            chk("rst_bcd", 64'(bcd), 64'h0);
            chk("rst_en", 64'(en), 64'h1);
            chk("rst_ovf", 64'(ovf), 64'h0);
            chk("rst_done", 64'(done), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
            chk("rst_en_nb", 64'(en_nb), 64'h1);
            last_bcd = '0;
            last_en  = 6'd1;
            last_ovf = 1'b0;
        end else begin
            exp_done = (q.size() > 0) && (q[0].fin == cyc);
            chk("busy", 64'(busy), 64'(m_active));
            chk("busy_nb", 64'(busy_nb), 64'(m_active));
            chk("done", 64'(done), 64'(exp_done));
            chk("done_nb", 64'(done_nb), 64'(exp_done));
            if (exp_done) begin
                e = q.pop_front();
                chk("bcd", 64'(bcd), 64'(e.bcd));
                chk("digit_en", 64'(en), 64'(e.en));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("bcd_nb", 64'(bcd_nb), 64'(e.bcd));
                chk("digit_en_nb", 64'(en_nb), 64'h3f);
                chk("ovf_nb", 64'(ovf_nb), 64'(e.ovf));
                last_bcd = e.bcd;
                last_en  = e.en;
                last_ovf = e.ovf;
            end else begin
                chk("hold_bcd", 64'(bcd), 64'(last_bcd));
                chk("hold_en", 64'(en), 64'(last_en));
                chk("hold_ovf", 64'(ovf), 64'(last_ovf));
            end
        end
    end

    task automatic drive(bit v, int unsigned val);
        bin_valid_i = v;
        bin_i       = 20'(val);
        @(posedge clk);
        #1;
        bin_valid_i = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 0);
    endtask

    function automatic int unsigned rand_val();
        int unsigned v;
        case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 120);
            1: v = $urandom_range(0, 20'hFFFFF);
            2: begin
                case ($urandom_range(0, 4))
                    0: v = 0;
                    1: v = 999983;
                    2: v = 999999;
                    3: v = 1000000;
                    default: v = 1048575;
                endcase
            end
            default: v = $urandom_range(999990, 1000010);
        endcase
        return v;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn_signal = 1'b1;
        idle(2);

        // Single conversions including saturation boundaries
        drive(1'b1, 0);       idle(25);
        drive(1'b1, 999983);  idle(25);
        drive(1'b1, 97);      idle(25);
        drive(1'b1, 999999);  idle(25);
        drive(1'b1, 1000000); idle(25);
        drive(1'b1, 1048575); idle(25);

        // Pending buffer: latest request during SHIFT wins
        for (int c = 0; c < 10; c++)
            drive(c == 0 || c == 5 || c == 9, (c == 0) ? 2 : (c == 5) ? 97 : 101);
        idle(50);

        // Request in FINISH overrides the pending value
        for (int c = 0; c < 22; c++)
            drive(c == 0 || c == 5 || c == 21, (c == 0) ? 2 : (c == 5) ? 97 : 113);
        idle(30);

        // Reset mid-conversion aborts it
        drive(1'b1, 524287);
        idle(9);
        rstn_signal = 1'b0;
        idle(2);
        rstn_signal = 1'b1;
        idle(1);
        drive(1'b1, 7);
        idle(25);
        drive(1'b1, 5);
        idle(25);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 5) == 0, rand_val());

        for (int i = 0; i < 100 && (q.size() != 0 || m_active); i++) idle(1);
        idle(2);
        chk("drain_queue", 64'(q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
